// File: rtl/mult_8x8_seq_nibble.sv
// Sequential 8x8 unsigned multiplier built on one shared 4x4 nibble multiplier.
// Optional MULT_SEQ_OR_COMBINE_EN: OR-recombination of partial products.
module mult_8x8_seq_nibble #(
  parameter int ACC_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       A,
  input  logic [7:0]       B,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] R
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state;
  logic [1:0]       step;
  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] r_q;
  logic [7:0]       a_q;
  logic [7:0]       b_q;

  logic [3:0]       na;
  logic [3:0]       nb;
  logic [7:0]       pp;
  logic [3:0]       sh;
  logic [ACC_W-1:0] term;
  logic [ACC_W-1:0] acc_nx;

  // Nibble select, shared 4x4 product and recombination for the current step
  always_comb begin
    na = step[1] ? a_q[7:4] : a_q[3:0];
    nb = step[0] ? b_q[7:4] : b_q[3:0];
    pp = na * nb;
    unique case (step)
      2'd0:    sh = 4'd0;
      2'd3:    sh = 4'd8;
      default: sh = 4'd4;
    endcase
    term = {{(ACC_W-8){1'b0}}, pp} << sh;
`ifdef MULT_SEQ_OR_COMBINE_EN
    acc_nx = acc | term;
`else
    acc_nx = acc + term;
`endif
  end

  // Control FSM, operand capture and accumulation
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      step  <= 2'd0;
      acc   <= '0;
      r_q   <= '0;
      a_q   <= 8'h00;
      b_q   <= 8'h00;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            a_q   <= A;
            b_q   <= B;
            acc   <= '0;
            step  <= 2'd0;
            state <= RUN;
          end
        end
        RUN: begin
          acc  <= acc_nx;
          step <= step + 2'd1;
          if (step == 2'd3) begin
            r_q   <= acc_nx;
            state <= DONE;
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Handshake outputs decoded from state; R holds the last completed product
  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
    R         = r_q;
  end

endmodule

// File: tb/tb_mult_8x8_seq_nibble.sv
// Directed self-checking bench for mult_8x8_seq_nibble.
// Table-driven products plus backpressure, reset and back-to-back sequences.
module tb_mult_8x8_seq_nibble;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  A;
  logic [7:0]  B;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] R;

  int checks = 0;
  int errors = 0;

  mult_8x8_seq_nibble #(.ACC_W(16)) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .A(A),
    .B(B),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .R(R)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Accept one operand pair, check latency/in_ready, check R, complete handshake
  task automatic run_op(input logic [7:0] a, input logic [7:0] b,
                        input logic [15:0] exp);
    int n;
    int busy_bad;
    n = 0;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("idle_ready", 32'(in_ready), 32'd1);
    A = a;
    B = b;
    in_valid = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    A = ~a;
    B = b ^ 8'h5A;
    busy_bad = 0;
    n = 0;
    while (!out_valid && n < 20) begin
      if (in_ready) busy_bad++;
      @(posedge clk);
      @(negedge clk);
      n++;
    end
    chk("latency", 32'(n), 32'd4);
    chk("in_ready_busy", 32'(busy_bad), 32'd0);
    chk("product", 32'(R), 32'(exp));
    chk("busy_in_done", 32'(in_ready), 32'd0);
    @(posedge clk);
    @(negedge clk);
    chk("hs_valid_low", 32'(out_valid), 32'd0);
    chk("hs_ready_high", 32'(in_ready), 32'd1);
  endtask

  initial begin
    vecs[0] = '{8'h12, 8'h34, 16'h03A8};
    vecs[1] = '{8'hFF, 8'hFF, 16'hFE01};
    vecs[2] = '{8'h00, 8'hAB, 16'h0000};
    vecs[3] = '{8'h0F, 8'h10, 16'h00F0};
    vecs[4] = '{8'hA5, 8'h5A, 16'h3A02};
    vecs[5] = '{8'h01, 8'hFF, 16'h00FF};
    vecs[6] = '{8'h0F, 8'h0F, 16'h00E1};
    vecs[7] = '{8'h80, 8'h80, 16'h4000};

    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    A = 8'h00;
    B = 8'h00;
    #12;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_R", 32'(R), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].exp);
    end

    // Backpressure: hold DONE for 10 cycles
    begin
      int n;
      int hold_bad;
      A = 8'h0F;
      B = 8'h10;
      out_ready = 1'b0;
      in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      n = 0;
      while (!out_valid && n < 20) begin
        @(negedge clk);
        n++;
      end
      chk("bp_latency", 32'(n), 32'd4);
      hold_bad = 0;
      for (int c = 0; c < 10; c++) begin
        if (!out_valid || R !== 16'h00F0 || in_ready) hold_bad++;
        @(negedge clk);
      end
      chk("bp_hold", 32'(hold_bad), 32'd0);
      chk("bp_R", 32'(R), 32'h00F0);
      out_ready = 1'b1;
      @(negedge clk);
      chk("bp_release_valid", 32'(out_valid), 32'd0);
      chk("bp_release_ready", 32'(in_ready), 32'd1);
    end

    // Reset in the middle of RUN
    A = 8'h80;
    B = 8'h80;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("midrst_valid", 32'(out_valid), 32'd0);
    chk("midrst_R", 32'(R), 32'd0);
    chk("midrst_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    begin
      int pulses = 0;
      for (int c = 0; c < 6; c++) begin
        @(negedge clk);
        if (out_valid) pulses++;
      end
      chk("midrst_no_pulse", 32'(pulses), 32'd0);
    end
    run_op(8'h80, 8'h80, 16'h4000);

    // Back-to-back with in_valid held high
    begin
      logic [7:0]  pa[3];
      logic [7:0]  pb[3];
      logic [15:0] pe[3];
      logic [15:0] got[$];
      int idx;
      int n;
      int overlap;
      pa = '{8'h01, 8'h10, 8'hF0};
      pb = '{8'h01, 8'h10, 8'h0F};
      pe = '{16'h0001, 16'h0100, 16'h0E10};
      idx = 0;
      n = 0;
      overlap = 0;
      out_ready = 1'b1;
      in_valid = 1'b1;
      while (got.size() < 3 && n < 100) begin
        if (out_valid) got.push_back(R);
        if (out_valid && in_ready) overlap++;
        if (in_ready) begin
          if (idx < 3) begin
            A = pa[idx];
            B = pb[idx];
            idx++;
          end else begin
            in_valid = 1'b0;
          end
        end
        @(negedge clk);
        n++;
      end
      in_valid = 1'b0;
      chk("b2b_count", 32'(got.size()), 32'd3);
      chk("b2b_overlap", 32'(overlap), 32'd0);
      for (int i = 0; i < 3; i++) begin
        if (i < got.size()) chk("b2b_R", 32'(got[i]), 32'(pe[i]));
        else chk("b2b_missing", 32'd0, 32'(pe[i]));
      end
      for (int c = 0; c < 8; c++) begin
        @(negedge clk);
        if (out_valid) got.push_back(R);
      end
      chk("b2b_no_dup", 32'(got.size()), 32'd3);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
